// File: rtl/ram_rw_host_pkg.sv
// Shared definitions for the RAM read/write host: command bytes, request ops, FSM states.
package ram_rw_host_pkg;

  typedef enum logic [7:0] {
    CMD_RST     = 8'h2A,
    CMD_RUN     = 8'h2B,
    CMD_CONF_WR = 8'h2C,
    CMD_CONF_RD = 8'h2D,
    CMD_DATA_WR = 8'h2E,
    CMD_DATA_RD = 8'h2F
  } cmd_t;

  typedef enum logic [2:0] {
    OP_RST     = 3'd0,
    OP_RUN     = 3'd1,
    OP_CONF_WR = 3'd2,
    OP_CONF_RD = 3'd3,
    OP_DATA_WR = 3'd4,
    OP_DATA_RD = 3'd5
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_CFG_TX,
    S_DAT_TX,
    S_CFG_RX,
    S_DAT_RX,
    S_FIN
  } state_t;

  localparam logic [7:0]  FAULT_BYTE = 8'hEF;
  localparam int unsigned CFG_BYTES  = 8;

  function automatic cmd_t op2cmd(input logic [2:0] op);
    case (op)
      OP_RUN:     return CMD_RUN;
      OP_CONF_WR: return CMD_CONF_WR;
      OP_CONF_RD: return CMD_CONF_RD;
      OP_DATA_WR: return CMD_DATA_WR;
      OP_DATA_RD: return CMD_DATA_RD;
      default:    return CMD_RST;
    endcase
  endfunction

endpackage

// File: rtl/ram_rw_host_edge2en.sv
// Rising-edge detector: turns a level-valid input into a single-cycle enable.
module edge2en (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic en_o
);

  logic sig_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) sig_q <= 1'b0;
    else          sig_q <= sig_i;
  end

  assign en_o = sig_i & ~sig_q;

endmodule

// File: rtl/ram_rw_host.sv
// Host that drives a UART-attached RAM: sends command/config/data bytes and
// collects config/data replies, with an idle timeout on the receive side.
module ram_rw_host
  import ram_rw_host_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RX_TIMEOUT = 1048576
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_vld_i,
  output logic            req_rdy_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_size_i,
  output logic [XLEN-1:0] src_rd_addr_o,
  input  logic [7:0]      src_rd_data_i,
  output logic            snk_wr_en_o,
  output logic [XLEN-1:0] snk_wr_addr_o,
  output logic [7:0]      snk_wr_data_o,
  output logic [7:0]      tx_data_o,
  output logic            tx_data_vld_o,
  input  logic            tx_data_rdy_i,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_data_vld_i,
  output logic            rx_data_rdy_o,
  output logic [XLEN-1:0] cfg_addr_o,
  output logic [XLEN-1:0] cfg_size_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            fault_o
);

  localparam logic [XLEN-1:0] CFG_LAST = XLEN'(CFG_BYTES - 1);
  localparam logic [31:0]     TMO_LAST = 32'(RX_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic [31:0]     tmo_q, tmo_d;
  logic [XLEN-1:0] host_addr_q, host_addr_d, host_size_q, host_size_d;
  logic [XLEN-1:0] cfg_addr_q, cfg_addr_d, cfg_size_q, cfg_size_d;
  logic [63:0]     rx_sh_q, rx_sh_d;
  logic            fault_q, fault_d, err_q, err_d, rx_rdy_q, rx_rdy_d;
  logic            snk_en_q, snk_en_d;
  logic [XLEN-1:0] snk_addr_q, snk_addr_d;
  logic [7:0]      snk_data_q, snk_data_d;

  logic            rx_ev;
  logic            tx_vld;
  logic [7:0]      tx_data;
  logic [63:0]     cfg_word;
  logic            cnt_last;
  logic            rx_state;

  edge2en u_rx_edge (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .sig_i   (rx_data_vld_i),
    .en_o    (rx_ev)
  );

  assign cfg_word = {32'(host_size_q), 32'(host_addr_q)};
  assign rx_state = (state_q == S_CFG_RX) || (state_q == S_DAT_RX);
  assign cnt_last = (state_q == S_CFG_TX || state_q == S_CFG_RX) ? (cnt_q == CFG_LAST)
                                                                   : (cnt_q == host_size_q);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;
    host_addr_d = host_addr_q;
    host_size_d = host_size_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_size_d  = cfg_size_q;
    rx_sh_d     = rx_sh_q;
    fault_d     = fault_q;
    err_d       = 1'b0;
    snk_en_d    = 1'b0;
    snk_addr_d  = snk_addr_q;
    snk_data_d  = snk_data_q;
    tx_vld      = 1'b0;
    tx_data     = '0;

    if (!rx_data_vld_i) rx_rdy_d = 1'b0;
    else if (rx_ev)     rx_rdy_d = 1'b1;
    else                rx_rdy_d = rx_rdy_q;

    if (rx_ev && rx_data_i == FAULT_BYTE && !rx_state && state_q != S_FIN)
      fault_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req_vld_i) begin
          op_d    = req_op_i;
          cnt_d   = '0;
          state_d = S_CMD;
          if (req_op_i == OP_CONF_WR) begin
            host_addr_d = req_addr_i;
            host_size_d = req_size_i;
          end
          if (req_op_i == OP_RST) fault_d = 1'b0;
        end
      end
      S_CMD: begin
        if (op_q > OP_DATA_RD) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tx_vld  = 1'b1;
          tx_data = op2cmd(op_q);
          if (tx_data_rdy_i) begin
            case (op_q)
              OP_CONF_WR: state_d = S_CFG_TX;
              OP_CONF_RD: state_d = S_CFG_RX;
              OP_DATA_WR: state_d = S_DAT_TX;
              OP_DATA_RD: state_d = S_DAT_RX;
              default:    state_d = S_FIN;
            endcase
          end
        end
      end
      S_CFG_TX, S_DAT_TX: begin
        tx_vld  = 1'b1;
        tx_data = (state_q == S_CFG_TX) ? cfg_word[{cnt_q[2:0], 3'b000} +: 8] : src_rd_data_i;
        if (tx_data_rdy_i) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + XLEN'(1);
          end
        end
      end
      S_CFG_RX, S_DAT_RX: begin
        if (rx_ev) begin
          if (state_q == S_CFG_RX) begin
            rx_sh_d = {rx_data_i, rx_sh_q[63:8]};
            if (cnt_last) begin
              cfg_addr_d = XLEN'(rx_sh_d[31:0]);
              cfg_size_d = XLEN'(rx_sh_d[63:32]);
            end
          end else begin
            snk_en_d   = 1'b1;
            snk_addr_d = cnt_q;
            snk_data_d = rx_data_i;
          end
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + XLEN'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      host_addr_q <= '0;
      host_size_q <= '0;
      cfg_addr_q  <= '0;
      cfg_size_q  <= '0;
      rx_sh_q     <= '0;
      fault_q     <= 1'b0;
      err_q       <= 1'b0;
      rx_rdy_q    <= 1'b0;
      snk_en_q    <= 1'b0;
      snk_addr_q  <= '0;
      snk_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      host_addr_q <= host_addr_d;
      host_size_q <= host_size_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_size_q  <= cfg_size_d;
      rx_sh_q     <= rx_sh_d;
      fault_q     <= fault_d;
      err_q       <= err_d;
      rx_rdy_q    <= rx_rdy_d;
      snk_en_q    <= snk_en_d;
      snk_addr_q  <= snk_addr_d;
      snk_data_q  <= snk_data_d;
    end
  end

  // The read address follows the next-state counter so the 1-cycle source
  // latency lands the byte exactly when it is presented, and holds it while stalled.
  assign src_rd_addr_o = ((state_q == S_CMD && op_q == OP_DATA_WR) || state_q == S_DAT_TX)
                         ? cnt_d : '0;

  assign req_rdy_o     = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_FIN);
  assign err_o         = err_q;
  assign fault_o       = fault_q;
  assign tx_data_o     = tx_data;
  assign tx_data_vld_o = tx_vld;
  assign rx_data_rdy_o = rx_rdy_q;
  assign snk_wr_en_o   = snk_en_q;
  assign snk_wr_addr_o = snk_addr_q;
  assign snk_wr_data_o = snk_data_q;
  assign cfg_addr_o    = cfg_addr_q;
  assign cfg_size_o    = cfg_size_q;

endmodule

// File: tb/tb_ram_rw_host.sv
// Directed bench for ram_rw_host: reset, each op, stalls, RX fault/timeout, mid-transfer reset.
module tb_ram_rw_host;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TMO  = 40;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_vld = 1'b0;
  logic            req_rdy;
  logic [2:0]      req_op = '0;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_size = '0;
  logic [XLEN-1:0] src_rd_addr;
  logic [7:0]      src_rd_data = '0;
  logic            snk_en;
  logic [XLEN-1:0] snk_addr;
  logic [7:0]      snk_data;
  logic [7:0]      tx_data;
  logic            tx_vld;
  logic            tx_rdy = 1'b1;
  logic [7:0]      rx_data = '0;
  logic            rx_vld = 1'b0;
  logic            rx_rdy;
  logic [XLEN-1:0] cfg_addr, cfg_size;
  logic            busy, done, err, fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_rw_host #(.XLEN(XLEN), .RX_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_size_i(req_size),
    .src_rd_addr_o(src_rd_addr), .src_rd_data_i(src_rd_data),
    .snk_wr_en_o(snk_en), .snk_wr_addr_o(snk_addr), .snk_wr_data_o(snk_data),
    .tx_data_o(tx_data), .tx_data_vld_o(tx_vld), .tx_data_rdy_i(tx_rdy),
    .rx_data_i(rx_data), .rx_data_vld_i(rx_vld), .rx_data_rdy_o(rx_rdy),
    .cfg_addr_o(cfg_addr), .cfg_size_o(cfg_size),
    .busy_o(busy), .done_o(done), .err_o(err), .fault_o(fault)
  );

  logic [7:0] src_mem [0:15];
  initial for (int i = 0; i < 16; i++) src_mem[i] = 8'(8'h11 * (i + 1));
  always @(posedge clk) src_rd_data <= src_mem[src_rd_addr[3:0]];

  // 0: ready always, 1: ready every other cycle, 2: never ready
  int rdy_mode = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       tx_rdy = 1'b1;
      1:       tx_rdy = ~tx_rdy;
      default: tx_rdy = 1'b0;
    endcase
  end

  logic [7:0]      tx_q[$];
  logic [XLEN-1:0] snk_a_q[$];
  logic [7:0]      snk_d_q[$];
  int   done_cnt = 0, err_cnt = 0, stall_viol = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall && (!tx_vld || tx_data !== prev_data)) stall_viol++;
      if (tx_vld && tx_rdy) tx_q.push_back(tx_data);
      prev_stall = tx_vld && !tx_rdy;
      prev_data  = tx_data;
      if (snk_en) begin snk_a_q.push_back(snk_addr); snk_d_q.push_back(snk_data); end
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    tx_q.delete(); snk_a_q.delete(); snk_d_q.delete();
    done_cnt = 0; err_cnt = 0; stall_viol = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] s);
    int n = 0;
    while (!req_rdy && n < 100) begin tick(); n++; end
    req_op = op; req_addr = a; req_size = s; req_vld = 1'b1;
    tick();
    req_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_wait: busy_o=%b required 0", busy); end
  endtask

  task automatic wait_cmd_sent();
    int n = 0;
    while (tx_q.size() < 1 && n < 50) begin tick(); n++; end
    checks++;
    if (tx_q.size() < 1) begin errors++; $display("FAIL cmd_wait: tx bytes=%0d required 1", tx_q.size()); end
  endtask

  task automatic send_rx(input logic [7:0] b);
    int n = 0;
    rx_data = b; rx_vld = 1'b1;
    do begin tick(); n++; end while (!rx_rdy && n < 20);
    checks++;
    if (rx_rdy !== 1'b1) begin errors++; $display("FAIL rx_rdy_wait: rx_data_rdy_o=%b required 1", rx_rdy); end
    rx_vld = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_rdy: got %b need 1", req_rdy); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b need 0", done); end
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b need 0", err); end
    checks++; if (fault !== 1'b0)   begin errors++; $display("FAIL reset_fault: got %b need 0", fault); end
    checks++; if (tx_vld !== 1'b0)  begin errors++; $display("FAIL reset_tx_vld: got %b need 0", tx_vld); end
    checks++; if (rx_rdy !== 1'b0)  begin errors++; $display("FAIL reset_rx_rdy: got %b need 0", rx_rdy); end
    checks++; if (snk_en !== 1'b0)  begin errors++; $display("FAIL reset_snk_en: got %b need 0", snk_en); end
    checks++; if (cfg_addr !== '0)  begin errors++; $display("FAIL reset_cfg_addr: got %h need 0", cfg_addr); end
    checks++; if (cfg_size !== '0)  begin errors++; $display("FAIL reset_cfg_size: got %h need 0", cfg_size); end
    checks++; if (src_rd_addr !== '0) begin errors++; $display("FAIL reset_src_addr: got %h need 0", src_rd_addr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_data_wr_default();
    logic [7:0] exp[$];
    logic [7:0] got;
    exp = '{8'h2E, 8'h11};
    clear_logs(); rdy_mode = 0;
    issue(3'd4, '0, '0);
    wait_idle();
    checks++; if (tx_q.size() != exp.size()) begin errors++; $display("FAIL dwr_default_len: got %0d need %0d", tx_q.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL dwr_default_byte%0d: got %h need %h", i, got, exp[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL dwr_default_done: got %0d need 1", done_cnt); end
  endtask

  task automatic test_conf_wr();
    logic [7:0] exp[$];
    logic [7:0] got;
    exp = '{8'h2C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    clear_logs(); rdy_mode = 0;
    issue(3'd2, 32'h0000_1000, 32'h0000_0003);
    wait_idle();
    checks++; if (tx_q.size() != exp.size()) begin errors++; $display("FAIL cwr_len: got %0d need %0d", tx_q.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL cwr_byte%0d: got %h need %h", i, got, exp[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL cwr_done: got %0d need 1", done_cnt); end
  endtask

  task automatic test_back_to_back_stall();
    logic [7:0] exp[$];
    logic [7:0] got;
    exp = '{8'h2E, 8'h11, 8'h22, 8'h33, 8'h44};
    clear_logs(); rdy_mode = 1;
    issue(3'd4, '0, '0);
    wait_idle();
    rdy_mode = 0;
    checks++; if (tx_q.size() != exp.size()) begin errors++; $display("FAIL dwr_stall_len: got %0d need %0d", tx_q.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL dwr_stall_byte%0d: got %h need %h", i, got, exp[i]); end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL dwr_stall_stable: unstable stalls=%0d need 0", stall_viol); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL dwr_stall_done: got %0d need 1", done_cnt); end
  endtask

  task automatic test_conf_rd();
    logic [7:0] rx[$];
    rx = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    clear_logs(); rdy_mode = 0;
    issue(3'd3, '0, '0);
    wait_cmd_sent();
    foreach (rx[i]) send_rx(rx[i]);
    wait_idle();
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h2D) begin errors++; $display("FAIL crd_cmd: got %0d bytes first %h need 1 byte 2d", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx); end
    checks++; if (cfg_addr !== 32'h0000_2000) begin errors++; $display("FAIL crd_addr: got %h need 00002000", cfg_addr); end
    checks++; if (cfg_size !== 32'h0000_0007) begin errors++; $display("FAIL crd_size: got %h need 00000007", cfg_size); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL crd_done: got %0d need 1", done_cnt); end
  endtask

  task automatic test_data_rd();
    clear_logs(); rdy_mode = 0;
    issue(3'd2, '0, 32'd1);
    wait_idle();
    clear_logs();
    issue(3'd5, '0, '0);
    wait_cmd_sent();
    send_rx(8'hEF);
    send_rx(8'h5A);
    wait_idle();
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h2F) begin errors++; $display("FAIL drd_cmd: got %0d bytes first %h need 1 byte 2f", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx); end
    checks++; if (snk_a_q.size() != 2) begin errors++; $display("FAIL drd_writes: got %0d need 2", snk_a_q.size()); end
    else begin
      checks++; if (snk_a_q[0] !== 32'd0 || snk_d_q[0] !== 8'hEF) begin errors++; $display("FAIL drd_w0: got addr %h data %h need 0 ef", snk_a_q[0], snk_d_q[0]); end
      checks++; if (snk_a_q[1] !== 32'd1 || snk_d_q[1] !== 8'h5A) begin errors++; $display("FAIL drd_w1: got addr %h data %h need 1 5a", snk_a_q[1], snk_d_q[1]); end
    end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL drd_fault: got %b need 0", fault); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL drd_done: got %0d need 1", done_cnt); end
  endtask

  task automatic test_fault();
    clear_logs(); rdy_mode = 0;
    send_rx(8'hEF);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b need 1", fault); end
    issue(3'd0, '0, '0);
    wait_idle();
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h2A) begin errors++; $display("FAIL fault_rst_cmd: got %0d bytes first %h need 1 byte 2a", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b need 0", fault); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL fault_rst_done: got %0d need 1", done_cnt); end
  endtask

  task automatic test_illegal();
    clear_logs(); rdy_mode = 0;
    issue(3'd6, '0, '0);
    wait_idle();
    repeat (2) tick();
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL illegal_err: pulses %0d need 1", err_cnt); end
    checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL illegal_tx: bytes %0d need 0", tx_q.size()); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL illegal_done: got %0d need 0", done_cnt); end
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_logs(); rdy_mode = 0;
    issue(3'd5, '0, '0);
    wait_cmd_sent();
    send_rx(8'h77);
    while (!err && n < int'(TMO) + 20) begin tick(); n++; end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: err_o=%b need 1 after %0d cycles", err, n); end
    checks++; if (n < int'(TMO) - 3 || n > int'(TMO) + 1) begin errors++; $display("FAIL tmo_latency: got %0d cycles need about %0d", n, TMO - 1); end
    tick();
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL tmo_done: got %0d need 0", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: busy_o=%b need 0", busy); end
    checks++; if (snk_a_q.size() != 1) begin errors++; $display("FAIL tmo_writes: got %0d need 1", snk_a_q.size()); end
  endtask

  task automatic test_reset_mid();
    clear_logs(); rdy_mode = 0;
    issue(3'd4, '0, '0);
    rdy_mode = 2;
    tick();
    checks++; if (tx_vld !== 1'b1 || tx_data !== 8'h11) begin errors++; $display("FAIL mid_dat_tx: vld %b data %h need 1 11", tx_vld, tx_data); end
    rst_n = 1'b0;
    tick();
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_tx_vld: got %b need 0", tx_vld); end
    checks++; if (req_rdy !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_idle: rdy %b busy %b need 1 0", req_rdy, busy); end
    rst_n = 1'b1;
    rdy_mode = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_data_wr_default();
    test_conf_wr();
    test_back_to_back_stall();
    test_conf_rd();
    test_data_rd();
    test_fault();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_rw_host.md
RAM_RW_HOST -- requirements
Module: ram_rw_host

Interface
REQ-001 Parameter XLEN, default 32, width of address, size and counter paths.
REQ-002 Parameter RX_TIMEOUT, default 1048576, maximum idle clock cycles allowed between expected response bytes.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_n_i  in  1  reset, synchronous, active-low.
REQ-005 req_vld_i / req_rdy_o  in/out  1/1  operation request handshake; accepted when both are high.
REQ-006 req_op_i  in  3  operation: 0 RST, 1 RUN, 2 CONF_WR, 3 CONF_RD, 4 DATA_WR, 5 DATA_RD; values 6-7 are illegal.
REQ-007 req_addr_i / req_size_i  in  XLEN/XLEN  CONF_WR payload; size is byte count minus 1.
REQ-008 src_rd_addr_o / src_rd_data_i  out/in  XLEN/8  byte source for DATA_WR; read latency is 1 cycle.
REQ-009 snk_wr_en_o / snk_wr_addr_o / snk_wr_data_o  out  1/XLEN/8  byte sink for DATA_RD.
REQ-010 tx_data_o / tx_data_vld_o / tx_data_rdy_i  out/out/in  8/1/1  byte stream to UART TX.
REQ-011 rx_data_i / rx_data_vld_i / rx_data_rdy_o  in/in/out  8/1/1  byte stream from UART RX; the level-valid input is converted to a 1-cycle event on its rising edge.
REQ-012 cfg_addr_o / cfg_size_o  out  XLEN/XLEN  values captured by CONF_RD.
REQ-013 busy_o, done_o (1-cycle pulse), err_o (timeout, 1-cycle pulse), fault_o (sticky)  out  1 each.

Function
REQ-014 Command bytes: RST 0x2A, RUN 0x2B, CONF_WR 0x2C, CONF_RD 0x2D, DATA_WR 0x2E, DATA_RD 0x2F.
REQ-015 FSM states: IDLE, CMD, CFG_TX, DAT_TX, CFG_RX, DAT_RX, FIN.
- IDLE -> CMD on request accept.
- CMD -> FIN for RST/RUN.
- CMD -> the matching payload state for all other ops.
- Payload state -> FIN at the last byte.
- FIN -> IDLE after 1 cycle.
REQ-016 req_rdy_o is high only in IDLE; an illegal op is accepted, sends nothing, and pulses err_o.
REQ-017 TX rule: tx_data_o is stable while tx_data_vld_o is high and tx_data_rdy_i is low; a byte completes on the cycle both are high.
REQ-018 CONF_WR sends the command byte, then 8 bytes: addr LSB first, then size LSB first; req_addr_i and req_size_i are latched at accept into shadow registers host_addr and host_size.
REQ-019 DATA_WR sends the command byte, then host_size+1 bytes.
- Byte k is read from src_rd_addr_o = k, k = 0..host_size.
- Each source read is issued one cycle before the byte is presented.
REQ-020 CONF_RD sends the command byte, then receives 8 bytes in the same order as REQ-018 into cfg_addr_o/cfg_size_o.
REQ-021 DATA_RD sends the command byte, then receives host_size+1 bytes; byte k is written to sink address k with a 1-cycle snk_wr_en_o pulse.
REQ-022 rx_data_rdy_o rises the cycle after an RX event and falls when rx_data_vld_i is low.
REQ-023 Byte counters are XLEN wide and end on counter == host_size (or 7 for config payloads); host_size = 0xFFFFFFFF transfers 2^32 bytes without overflow misdetection.
REQ-024 Before the first CONF_WR after reset, host_size = 0, so DATA_WR and DATA_RD move exactly 1 byte.
REQ-025 A byte 0xEF received in IDLE, CMD, CFG_TX or DAT_TX sets fault_o; only RST or reset clears it.
- In CFG_RX and DAT_RX, 0xEF is treated as data.
REQ-026 In CFG_RX and DAT_RX, RX_TIMEOUT cycles without an RX event pulse err_o and return the FSM to IDLE; no done_o is issued.
REQ-027 done_o pulses in FIN; busy_o is high in every state except IDLE.

Reset
REQ-028 While rst_n_i is low at a clock edge, the block enters IDLE and all outputs go to 0 except req_rdy_o, which goes to 1.
- host_addr, host_size, cfg_addr_o, cfg_size_o, counters and fault_o are cleared.
REQ-029 Reset asserted mid-transfer aborts the transfer at the next edge; a partially sent byte is dropped (tx_data_vld_o = 0).

Structure
REQ-030 A shared package holds: the command-code enum (REQ-014), fault byte 0xEF, config byte count 8, and the request-op enum.
REQ-031 The codebase's existing edge2en is instantiated once, for rx_data_vld_i; no other sub-module is used.

Verification
REQ-032 CONF_WR addr 0x00001000, size 0x00000003 with rdy always high -> TX bytes 2C 00 10 00 00 03 00 00 00, then a done_o pulse.
REQ-033 DATA_WR after REQ-032, source = 11 22 33 44, tx_data_rdy_i low every other cycle -> TX bytes 2E 11 22 33 44, each held stable while stalled.
REQ-034 CONF_RD, responder replies 00 20 00 00 07 00 00 00 -> cfg_addr_o = 0x00002000, cfg_size_o = 0x00000007.
REQ-035 DATA_RD with host_size 1, RX bytes EF 5A -> sink writes addr 0 = 0xEF, addr 1 = 0x5A; fault_o stays 0.
REQ-036 RX byte EF while IDLE -> fault_o = 1; a following RST op sends 2A and clears fault_o.
REQ-037 DATA_RD with only 1 of 2 bytes received -> err_o pulses after RX_TIMEOUT cycles and no done_o is issued; separately, reset during DAT_TX -> IDLE and tx_data_vld_o = 0 at the next edge.
